alu_sched: RTL and testbench

Two-requester scheduler for the shared 64-bit integer/logic ALU (ops 0–9: AND, OR, XOR, NOT, SHR, SHL, ADD, SUB, MUL, DIV). It accepts operations from two independent valid/ready request ports and arbitrates between them round-robin. It drives the ALU's operand/opcode inputs from registers, holds them stable for a per-opcode number of cycles (MUL/DIV are multicycle paths), captures the result, and returns it on a single valid/ready response port tagged with the requester ID. It also traps divide-by-zero and illegal opcodes so the unchecked ALU DIV never produces an undefined value downstream.

---
 rtl/alu_sched_if.sv | 46 ++++
 rtl/alu_sched.sv | 143 ++++++++++++++
 tb/tb_alu_sched.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sched_if.sv
// Request, ALU and response signal bundle for the two-requester ALU scheduler.
interface alu_sched_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [3:0]  req0_op;
  logic [63:0] req0_a;
  logic [63:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [3:0]  req1_op;
  logic [63:0] req1_a;
  logic [63:0] req1_b;
  logic [63:0] alu_operand1;
  logic [63:0] alu_operand2;
  logic [3:0]  alu_op;
  logic [63:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [63:0] rsp_result;
  logic        rsp_err;

  // Scheduler side: accepts requests, drives the ALU, returns responses.
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output alu_operand1, alu_operand2, alu_op,
    input  alu_result,
    output rsp_valid, rsp_id, rsp_result, rsp_err,
    input  rsp_ready
  );

  // Environment side: requesters, the ALU itself and the response consumer.
  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  alu_operand1, alu_operand2, alu_op,
    output alu_result,
    input  rsp_valid, rsp_id, rsp_result, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_sched.sv
// Round-robin scheduler for a shared 64-bit ALU: holds operands for a
// per-opcode number of cycles, captures the result, traps DIV-by-zero and
// illegal opcodes, and returns a tagged response.
module alu_sched #(
  parameter int unsigned MUL_CYCLES = 3,
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  alu_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] op1_q, op1_d;
  logic [63:0] op2_q, op2_d;
  logic [3:0]  op_q, op_d;
  logic [63:0] res_q, res_d;
  logic        id_q, id_d;
  logic        err_q, err_d;

  logic        grant;
  logic        accept;
  logic [3:0]  sel_op;
  logic [63:0] sel_a;
  logic [63:0] sel_b;

  // Arbitration: on a tie the requester not granted last time wins.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant_q;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
    accept = (state_q == IDLE) && !reset && (bus.req0_valid || bus.req1_valid);
    bus.req0_ready = accept && !grant;
    bus.req1_ready = accept && grant;
    sel_op = grant ? bus.req1_op : bus.req0_op;
    sel_a  = grant ? bus.req1_a  : bus.req0_a;
    sel_b  = grant ? bus.req1_b  : bus.req0_b;
  end

  // Next-state: acceptance, latency countdown, trap handling, response drain.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    op_d         = op_q;
    res_d        = res_q;
    id_d         = id_q;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op1_d        = sel_a;
          op2_d        = sel_b;
          op_d         = sel_op;
          id_d         = grant;
          last_grant_d = grant;
          if (sel_op >= 4'd10) begin
            res_d   = '0;
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = RESP;
          end else if (sel_op == 4'd9 && sel_b == '0) begin
            res_d   = '1;
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = RESP;
          end else begin
            if (sel_op == 4'd8) begin
              cnt_d = 4'(MUL_CYCLES - 1);
            end else if (sel_op == 4'd9) begin
              cnt_d = 4'(DIV_CYCLES - 1);
            end else begin
              cnt_d = '0;
            end
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          res_d   = bus.alu_result;
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      op_q         <= '0;
      res_q        <= '0;
      id_q         <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      op_q         <= op_d;
      res_q        <= res_d;
      id_q         <= id_d;
      err_q        <= err_d;
    end
  end

  assign bus.alu_operand1 = op1_q;
  assign bus.alu_operand2 = op2_q;
  assign bus.alu_op       = op_q;
  assign bus.rsp_valid    = (state_q == RESP);
  assign bus.rsp_id       = id_q;
  assign bus.rsp_result   = res_q;
  assign bus.rsp_err      = err_q;

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched with a behavioural ALU and reference model.
module tb_alu_sched;
  localparam int unsigned MULC = 3;
  localparam int unsigned DIVC = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  alu_sched_if bus ();

  alu_sched #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural external ALU; divide-by-zero returns a marker value.
  always_comb begin
    case (bus.alu_op)
      4'd0: bus.alu_result = bus.alu_operand1 & bus.alu_operand2;
      4'd1: bus.alu_result = bus.alu_operand1 | bus.alu_operand2;
      4'd2: bus.alu_result = bus.alu_operand1 ^ bus.alu_operand2;
      4'd3: bus.alu_result = ~bus.alu_operand1;
      4'd4: bus.alu_result = bus.alu_operand1 >> bus.alu_operand2[5:0];
      4'd5: bus.alu_result = bus.alu_operand1 << bus.alu_operand2[5:0];
      4'd6: bus.alu_result = bus.alu_operand1 + bus.alu_operand2;
      4'd7: bus.alu_result = bus.alu_operand1 - bus.alu_operand2;
      4'd8: bus.alu_result = bus.alu_operand1 * bus.alu_operand2;
      4'd9: bus.alu_result = (bus.alu_operand2 == 64'd0) ? 64'h0BAD : bus.alu_operand1 / bus.alu_operand2;
      default: bus.alu_result = 64'h0BAD_0BAD;
    endcase
  end

  // Reference: result, error flag and accept-to-rsp_valid latency.
  task automatic model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] res, output logic err, output int lat);
    err = 1'b0;
    lat = 2;
    case (op)
      4'd0: res = a & b;
      4'd1: res = a | b;
      4'd2: res = a ^ b;
      4'd3: res = ~a;
      4'd4: res = a >> b[5:0];
      4'd5: res = a << b[5:0];
      4'd6: res = a + b;
      4'd7: res = a - b;
      4'd8: begin res = a * b; lat = MULC + 1; end
      4'd9: begin
        if (b == 64'd0) begin res = {64{1'b1}}; err = 1'b1; lat = 1; end
        else begin res = a / b; lat = DIVC + 1; end
      end
      default: begin res = 64'd0; err = 1'b1; lat = 1; end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit port, input logic v, input logic [3:0] op,
                         input logic [63:0] a, input logic [63:0] b);
    if (port == 1'b0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  // Present a request and wait (bounded) for its handshake; returns one cycle after accept.
  task automatic issue(input bit port, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, output bit ok);
    bit got;
    got = 1'b0;
    set_req(port, 1'b1, op, a, b);
    for (int i = 0; i < 40; i++) begin
      #1;
      got = (port == 1'b0) ? bus.req0_ready : bus.req1_ready;
      tick();
      if (got) break;
    end
    if (port == 1'b0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
    ok = got;
  endtask

  // Count cycles until rsp_valid, noting whether alu_* held the request throughout.
  task automatic wait_rsp(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          output int lat, output bit seen, output bit stable);
    lat = 1;
    stable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.alu_op !== op || bus.alu_operand1 !== a || bus.alu_operand2 !== b) stable = 1'b0;
      if (bus.rsp_valid === 1'b1) begin seen = 1'b1; break; end
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_req(0, 1'b1, 4'd6, 64'd1, 64'd1);
    tick(); tick();
    checks++;
    if (bus.req0_ready !== 1'b0) $display("FAIL reset_ready0 got=%b exp=0", bus.req0_ready);
    else passes++;
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_result, bus.alu_operand1, bus.alu_operand2, bus.alu_op} !== '0)
      $display("FAIL reset_outputs got valid=%b id=%b err=%b res=%h op1=%h op2=%h op=%h exp all zero",
               bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_result, bus.alu_operand1, bus.alu_operand2, bus.alu_op);
    else passes++;
    set_req(0, 1'b0, 4'd0, 64'd0, 64'd0);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_add();
    bit ok, seen, st; int lat;
    issue(0, 4'd6, 64'd5, 64'd7, ok);
    checks++;
    if (!ok) $display("FAIL add_accept got=no_ready exp=ready"); else passes++;
    wait_rsp(4'd6, 64'd5, 64'd7, lat, seen, st);
    checks++;
    if (!seen || lat != 2) $display("FAIL add_latency got=%0d seen=%b exp=2", lat, seen); else passes++;
    checks++;
    if (bus.rsp_result !== 64'd12 || bus.rsp_id !== 1'b0 || bus.rsp_err !== 1'b0)
      $display("FAIL add_rsp got res=%0d id=%b err=%b exp res=12 id=0 err=0", bus.rsp_result, bus.rsp_id, bus.rsp_err);
    else passes++;
    tick();
  endtask

  task automatic test_tie();
    bit seen, st; int lat;
    reset = 1'b1;
    set_req(0, 1'b1, 4'd0, 64'hF0, 64'h3C);
    set_req(1, 1'b1, 4'd7, 64'd10, 64'd3);
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0)
      $display("FAIL tie_first_grant got r0=%b r1=%b exp r0=1 r1=0", bus.req0_ready, bus.req1_ready);
    else passes++;
    tick();
    bus.req0_valid = 1'b0;
    wait_rsp(4'd0, 64'hF0, 64'h3C, lat, seen, st);
    checks++;
    if (!seen || bus.rsp_result !== 64'h30 || bus.rsp_id !== 1'b0)
      $display("FAIL tie_rsp0 got seen=%b res=%h id=%b exp res=30 id=0", seen, bus.rsp_result, bus.rsp_id);
    else passes++;
    tick();
    #1;
    checks++;
    if (bus.req1_ready !== 1'b1) $display("FAIL tie_loser_next got r1=%b exp 1", bus.req1_ready); else passes++;
    tick();
    bus.req1_valid = 1'b0;
    wait_rsp(4'd7, 64'd10, 64'd3, lat, seen, st);
    checks++;
    if (!seen || bus.rsp_result !== 64'd7 || bus.rsp_id !== 1'b1)
      $display("FAIL tie_rsp1 got seen=%b res=%0d id=%b exp res=7 id=1", seen, bus.rsp_result, bus.rsp_id);
    else passes++;
    tick();
    set_req(0, 1'b1, 4'd6, 64'd1, 64'd1);
    set_req(1, 1'b1, 4'd6, 64'd2, 64'd2);
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0)
      $display("FAIL retie_grant got r0=%b r1=%b exp r0=1 r1=0", bus.req0_ready, bus.req1_ready);
    else passes++;
    tick();
    bus.req0_valid = 1'b0;
    wait_rsp(4'd6, 64'd1, 64'd1, lat, seen, st);
    checks++;
    if (!seen || bus.rsp_result !== 64'd2 || bus.rsp_id !== 1'b0)
      $display("FAIL retie_rsp got seen=%b res=%0d id=%b exp res=2 id=0", seen, bus.rsp_result, bus.rsp_id);
    else passes++;
    tick();
    bus.req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_mul();
    bit ok, seen, st; int lat;
    issue(1, 4'd8, 64'hFFFF_FFFF, 64'd2, ok);
    wait_rsp(4'd8, 64'hFFFF_FFFF, 64'd2, lat, seen, st);
    checks++;
    if (!ok || !seen || lat != int'(MULC + 1))
      $display("FAIL mul_latency got ok=%b seen=%b lat=%0d exp lat=%0d", ok, seen, lat, MULC + 1);
    else passes++;
    checks++;
    if (bus.rsp_result !== 64'h1_FFFF_FFFE || bus.rsp_id !== 1'b1 || bus.rsp_err !== 1'b0)
      $display("FAIL mul_rsp got res=%h id=%b err=%b exp res=1fffffffe id=1 err=0", bus.rsp_result, bus.rsp_id, bus.rsp_err);
    else passes++;
    checks++;
    if (!st) $display("FAIL mul_alu_stable got unstable exp stable"); else passes++;
    tick();
  endtask

  task automatic test_traps();
    bit ok, seen, st; int lat;
    issue(0, 4'd9, 64'd100, 64'd0, ok);
    wait_rsp(4'd9, 64'd100, 64'd0, lat, seen, st);
    checks++;
    if (!ok || !seen || lat != 1 || bus.rsp_result !== {64{1'b1}} || bus.rsp_err !== 1'b1 || !st)
      $display("FAIL div0_trap got lat=%0d res=%h err=%b alu_loaded=%b exp lat=1 res=all-ones err=1 alu_loaded=1",
               lat, bus.rsp_result, bus.rsp_err, st);
    else passes++;
    tick();
    issue(1, 4'd12, 64'd55, 64'd66, ok);
    wait_rsp(4'd12, 64'd55, 64'd66, lat, seen, st);
    checks++;
    if (!ok || !seen || lat != 1 || bus.rsp_result !== 64'd0 || bus.rsp_err !== 1'b1 || bus.rsp_id !== 1'b1)
      $display("FAIL illegal_op got lat=%0d res=%h err=%b id=%b exp lat=1 res=0 err=1 id=1",
               lat, bus.rsp_result, bus.rsp_err, bus.rsp_id);
    else passes++;
    tick();
    issue(0, 4'd9, 64'd100, 64'd7, ok);
    wait_rsp(4'd9, 64'd100, 64'd7, lat, seen, st);
    checks++;
    if (!ok || !seen || lat != int'(DIVC + 1) || bus.rsp_result !== 64'd14 || bus.rsp_err !== 1'b0)
      $display("FAIL div_ok got lat=%0d res=%0d err=%b exp lat=%0d res=14 err=0", lat, bus.rsp_result, bus.rsp_err, DIVC + 1);
    else passes++;
    tick();
  endtask

  task automatic test_backpressure();
    bit ok, seen, st; int lat;
    bus.rsp_ready = 1'b0;
    issue(0, 4'd2, 64'hAAAA, 64'h0F0F, ok);
    set_req(1, 1'b1, 4'd1, 64'h100, 64'h001);
    wait_rsp(4'd2, 64'hAAAA, 64'h0F0F, lat, seen, st);
    checks++;
    if (!ok || !seen) $display("FAIL bp_rsp_arrive got ok=%b seen=%b exp 1 1", ok, seen); else passes++;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 64'hA5A5 || bus.rsp_id !== 1'b0 || bus.req1_ready !== 1'b0)
        $display("FAIL bp_hold[%0d] got v=%b res=%h id=%b r1=%b exp v=1 res=a5a5 id=0 r1=0",
                 i, bus.rsp_valid, bus.rsp_result, bus.rsp_id, bus.req1_ready);
      else passes++;
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req1_ready !== 1'b0) $display("FAIL bp_handshake_ready got r1=%b exp 0", bus.req1_ready); else passes++;
    tick();
    #1;
    checks++;
    if (bus.req1_ready !== 1'b1) $display("FAIL bp_after_ready got r1=%b exp 1", bus.req1_ready); else passes++;
    tick();
    bus.req1_valid = 1'b0;
    wait_rsp(4'd1, 64'h100, 64'h001, lat, seen, st);
    checks++;
    if (!seen || bus.rsp_result !== 64'h101 || bus.rsp_id !== 1'b1)
      $display("FAIL bp_next_rsp got res=%h id=%b exp res=101 id=1", bus.rsp_result, bus.rsp_id);
    else passes++;
    tick();
  endtask

  task automatic test_reset_midop();
    bit ok, seen, st, any_valid; int lat;
    issue(0, 4'd9, 64'd100, 64'd7, ok);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_result, bus.alu_operand1, bus.alu_operand2, bus.alu_op} !== '0)
      $display("FAIL midreset_outputs got v=%b res=%h op1=%h op=%h exp all zero",
               bus.rsp_valid, bus.rsp_result, bus.alu_operand1, bus.alu_op);
    else passes++;
    any_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.rsp_valid !== 1'b0) any_valid = 1'b1;
      tick();
    end
    checks++;
    if (any_valid) $display("FAIL midreset_no_rsp got rsp_valid seen exp none"); else passes++;
    issue(1, 4'd4, 64'h8000, 64'd4, ok);
    wait_rsp(4'd4, 64'h8000, 64'd4, lat, seen, st);
    checks++;
    if (!ok || !seen || lat != 2 || bus.rsp_result !== 64'h800 || bus.rsp_id !== 1'b1)
      $display("FAIL midreset_next got lat=%0d res=%h id=%b exp lat=2 res=800 id=1", lat, bus.rsp_result, bus.rsp_id);
    else passes++;
    tick();
  endtask

  task automatic test_random();
    bit ok, seen, st, port; int lat, elat, hold;
    logic [3:0] op; logic [63:0] a, b, eres; logic eerr;
    for (int n = 0; n < 40; n++) begin
      port = 1'($urandom_range(0, 1));
      op   = 4'($urandom_range(0, 15));
      a    = {$urandom(), $urandom()};
      b    = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom(), $urandom()};
      if (op == 4'd9 && b != 64'd0) b = {32'd0, 32'($urandom_range(1, 100000))};
      hold = $urandom_range(0, 2);
      model(op, a, b, eres, eerr, elat);
      bus.rsp_ready = (hold == 0);
      issue(port, op, a, b, ok);
      wait_rsp(op, a, b, lat, seen, st);
      checks++;
      if (!ok || !seen || lat != elat || bus.rsp_result !== eres || bus.rsp_err !== eerr || bus.rsp_id !== port || !st)
        $display("FAIL rand[%0d] op=%0d got lat=%0d res=%h err=%b id=%b stable=%b exp lat=%0d res=%h err=%b id=%b stable=1",
                 n, op, lat, bus.rsp_result, bus.rsp_err, bus.rsp_id, st, elat, eres, eerr, port);
      else passes++;
      repeat (hold) tick();
      bus.rsp_ready = 1'b1;
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.rsp_ready = 1'b1;
    set_req(0, 1'b0, 4'd0, 64'd0, 64'd0);
    set_req(1, 1'b0, 4'd0, 64'd0, 64'd0);
    test_reset();
    test_add();
    test_tie();
    test_mul();
    test_traps();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "timeout");
  end
endmodule
